// File: rtl/cv32e40px_apu_core_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40px_apu_core_pkg
// Shared APU width constants for the core-side APU logic, plus the writeback
// record type produced by the APU transaction tracker.
//   APU_NARGS_CPU     operand count per request
//   APU_WOP_CPU       opcode width
//   APU_NDSFLAGS_CPU  downstream (core -> APU) flag width
//   APU_NUSFLAGS_CPU  upstream (APU -> core) flag width
//   APU_WADDR_W       register-file address width
//   APU_NRADDR        decode-stage source operands checked for hazards
// -----------------------------------------------------------------------------
package cv32e40px_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;
  localparam int APU_WADDR_W      = 6;
  localparam int APU_NRADDR       = 3;

  // One completed APU operation on its way to the register file.
  typedef struct packed {
    logic [31:0]                 result;
    logic [APU_NUSFLAGS_CPU-1:0] flags;
    logic [APU_WADDR_W-1:0]      waddr;
  } apu_wb_t;

endpackage

// File: rtl/cv32e40px_apu_txn_tracker_if.sv
// -----------------------------------------------------------------------------
// cv32e40px_apu_txn_tracker_if
// Link between the APU transaction tracker (master) and the shared APU
// interconnect (slave).
//   req / gnt          request handshake: a transfer happens in every cycle
//                      where req and gnt are both high; req is withdrawn
//                      freely and gnt only matters while req is high.
//   operands/op/ds_flags  request payload, valid while req is high.
//   rvalid             response strobe; it cannot be back-pressured, so the
//                      master must consume result/us_flags in that cycle.
//   result / us_flags  response payload, valid while rvalid is high.
// -----------------------------------------------------------------------------
interface cv32e40px_apu_txn_tracker_if #(
  parameter int NARGS    = cv32e40px_apu_core_pkg::APU_NARGS_CPU,
  parameter int WOP      = cv32e40px_apu_core_pkg::APU_WOP_CPU,
  parameter int NDSFLAGS = cv32e40px_apu_core_pkg::APU_NDSFLAGS_CPU,
  parameter int NUSFLAGS = cv32e40px_apu_core_pkg::APU_NUSFLAGS_CPU
);

  logic                       req;
  logic                       gnt;
  logic [NARGS-1:0][31:0]     operands;
  logic [WOP-1:0]             op;
  logic [NDSFLAGS-1:0]        ds_flags;
  logic                       rvalid;
  logic [31:0]                result;
  logic [NUSFLAGS-1:0]        us_flags;

  modport master (
    output req, operands, op, ds_flags,
    input  gnt, rvalid, result, us_flags
  );

  modport slave (
    input  req, operands, op, ds_flags,
    output gnt, rvalid, result, us_flags
  );

endinterface

// File: rtl/cv32e40px_apu_tag_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40px_apu_tag_fifo
// In-order FIFO of destination-register tags for in-flight APU operations.
// Every slot and its valid bit are visible so the caller can run a hazard
// compare against all pending destinations at once.
//   push_en / push_data   write a tag at the write pointer (caller never
//                         pushes when full)
//   pop_en                retire the head (caller never pops when empty)
//   head_data             tag at the read pointer
//   entries / entry_valid all slots and their occupancy
//   count                 number of occupied slots
// -----------------------------------------------------------------------------
module cv32e40px_apu_tag_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 6,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_en,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop_en,
  output logic [WIDTH-1:0]            head_data,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [CW-1:0]               count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            valid_q;
  logic [PW-1:0]               wr_ptr_q;
  logic [PW-1:0]               rd_ptr_q;
  logic [CW-1:0]               count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Clear before set: with push and pop together the slots differ, since
      // a push is only allowed when not full and a pop only when not empty.
      if (pop_en) begin
        valid_q[rd_ptr_q] <= 1'b0;
        if (rd_ptr_q == PW'(DEPTH - 1)) rd_ptr_q <= '0;
        else                            rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_en) begin
        mem_q[wr_ptr_q]   <= push_data;
        valid_q[wr_ptr_q] <= 1'b1;
        if (wr_ptr_q == PW'(DEPTH - 1)) wr_ptr_q <= '0;
        else                            wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data   = mem_q[rd_ptr_q];
  assign entries     = mem_q;
  assign entry_valid = valid_q;
  assign count       = count_q;

endmodule

// File: rtl/cv32e40px_apu_txn_tracker.sv
// -----------------------------------------------------------------------------
// cv32e40px_apu_txn_tracker
// Sits between the EX stage and the shared APU interconnect. Forwards requests
// (payload is a pure pass-through), remembers the destination register of each
// accepted request in order, and pairs every response with its destination for
// a one-cycle-registered writeback. Also raises a RAW hazard when a decode
// source matches any pending destination.
//   clk, rst_n                 clock, asynchronous active-low reset
//   core_req_i / core_gnt_o    EX-side request handshake
//   core_operands_i/op/flags   request payload
//   core_waddr_i               destination register of the request
//   core_raddr_i               decode-stage sources for the hazard check
//   raw_hazard_o               a source matches a pending destination
//   apu                        interconnect side (request + response)
//   wb_valid_o/result/flags/waddr  registered writeback, one pulse per response
//   busy_o / count_o           in-flight status
//   proto_err_o                sticky: response seen with nothing in flight
// -----------------------------------------------------------------------------
module cv32e40px_apu_txn_tracker
  import cv32e40px_apu_core_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  parameter  int NARGS           = APU_NARGS_CPU,
  parameter  int WOP             = APU_WOP_CPU,
  parameter  int NDSFLAGS        = APU_NDSFLAGS_CPU,
  parameter  int NUSFLAGS        = APU_NUSFLAGS_CPU,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 core_req_i,
  output logic                                 core_gnt_o,
  input  logic [NARGS-1:0][31:0]               core_operands_i,
  input  logic [WOP-1:0]                       core_op_i,
  input  logic [NDSFLAGS-1:0]                  core_flags_i,
  input  logic [APU_WADDR_W-1:0]               core_waddr_i,
  input  logic [APU_NRADDR-1:0][APU_WADDR_W-1:0] core_raddr_i,
  output logic                                 raw_hazard_o,
  cv32e40px_apu_txn_tracker_if.master          apu,
  output logic                                 wb_valid_o,
  output logic [31:0]                          wb_result_o,
  output logic [NUSFLAGS-1:0]                  wb_flags_o,
  output logic [APU_WADDR_W-1:0]               wb_waddr_o,
  output logic                                 busy_o,
  output logic [CW-1:0]                        count_o,
  output logic                                 proto_err_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic                                           full;
  logic                                           push;
  logic                                           pop;
  logic [APU_WADDR_W-1:0]                         head_waddr;
  logic [MAX_OUTSTANDING-1:0][APU_WADDR_W-1:0]    tag_entries;
  logic [MAX_OUTSTANDING-1:0]                     tag_valid;
  logic [CW-1:0]                                  count;

  apu_wb_t wb_q;
  logic    wb_valid_q;
  logic    proto_err_q;

  // Full is taken from the registered count only, so a response in the same
  // cycle never opens a slot and rvalid has no path to the grant.
  assign full       = (count == MAX_CNT);
  assign apu.req    = core_req_i & ~full;
  assign core_gnt_o = apu.req & apu.gnt;

  assign apu.operands = core_operands_i;
  assign apu.op       = core_op_i;
  assign apu.ds_flags = core_flags_i;

  assign push = core_gnt_o;
  assign pop  = apu.rvalid & (count != '0);

  cv32e40px_apu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (APU_WADDR_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_en     (push),
    .push_data   (core_waddr_i),
    .pop_en      (pop),
    .head_data   (head_waddr),
    .entries     (tag_entries),
    .entry_valid (tag_valid),
    .count       (count)
  );

  // Only pending FIFO entries are compared; the wb stage is forwarded
  // downstream. A nonzero entry matching a source implies the source is
  // nonzero too, so x0 never hazards.
  always_comb begin
    raw_hazard_o = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      for (int j = 0; j < APU_NRADDR; j++) begin
        if (tag_valid[i] && (tag_entries[i] != '0) &&
            (core_raddr_i[j] == tag_entries[i])) begin
          raw_hazard_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wb_valid_q <= pop;
      if (pop) begin
        wb_q.result <= apu.result;
        wb_q.flags  <= apu.us_flags;
        wb_q.waddr  <= head_waddr;
      end
      if (apu.rvalid && (count == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_result_o = wb_q.result;
  assign wb_flags_o  = wb_q.flags;
  assign wb_waddr_o  = wb_q.waddr;
  assign busy_o      = (count != '0);
  assign count_o     = count;
  assign proto_err_o = proto_err_q;

endmodule
